mult_share_sequencer: RTL and testbench

- Shares one 8x8 shift-add multiplier among N requesters. The multiplier has a shared 8-bit databus and uses start / lsb_out / msb_out / done.
- Arbitrates the requesters round-robin and captures the winner's operands.
- Runs the multiplier's bus protocol: start, drive A, drive B, release the bus, collect the low and high product bytes.
- Returns the 16-bit product to the winner. Sits between the client blocks and the Multiplier top.

---
 rtl/mult_share_sequencer_pkg.sv | 18 +
 rtl/mult_share_sequencer_rr_arbiter.sv | 34 +++
 rtl/mult_share_sequencer.sv | 124 ++++++++++++
 tb/tb_mult_share_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_sequencer_pkg.sv
// Shared types and widths for the multiplier-sharing sequencer.
// Holds the FSM state encoding plus the operand and product widths.
package mult_share_sequencer_pkg;

  localparam int BYTE_W      = 8;
  localparam int PROD_W      = 2 * BYTE_W;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DRV_A,
    DRV_B,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mult_share_sequencer_rr_arbiter.sv
// Round-robin pick: the first set request above rr_ptr, wrapping around.
// Purely combinational, so there is no latency; requests that lose simply stay pending.
module mult_share_sequencer_rr_arbiter
  import mult_share_sequencer_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    // Search starts just past the last winner, so that winner ends up with the lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!win_vld && req[cand]) begin
        win_vld      = 1'b1;
        win_idx      = cand;
        win_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_sequencer.sv
// Shares one 8x8 shift-add multiplier among N_REQ clients, granting them round-robin.
// Latency: gnt leads mul_start by 1 cycle, and the response follows mul_done by 1 cycle. Clients keep req held until gnt.
module mult_share_sequencer
  import mult_share_sequencer_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [BYTE_W*N_REQ-1:0] op_a,
  input  logic [BYTE_W*N_REQ-1:0] op_b,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [PROD_W-1:0]       rsp_product,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    mul_start,
  inout  wire  [BYTE_W-1:0]       mul_databus,
  input  logic                    mul_lsb_out,
  input  logic                    mul_msb_out,
  input  logic                    mul_done
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, win_q;
  logic [BYTE_W-1:0]  a_q, b_q, lo_q, hi_q, bus_dat;
  logic [TMR_W-1:0]   timer;
  logic               err_q, bus_oe, tmo_hit;
  logic [N_REQ-1:0]   arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;

  mult_share_sequencer_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win_oh  (arb_oh),
    .win_idx (arb_idx),
    .win_vld (arb_vld)
  );

  assign tmo_hit = (timer == TMR_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt   = state;
    gnt         = '0;
    rsp_valid   = '0;
    rsp_product = '0;
    rsp_err     = 1'b0;
    busy        = 1'b1;
    mul_start   = 1'b0;
    case (state)
      IDLE: begin
        busy = arb_vld;
        if (arb_vld) begin
          gnt       = arb_oh;
          state_nxt = START;
        end
      end
      START: begin
        mul_start = 1'b1;
        state_nxt = DRV_A;
      end
      DRV_A: state_nxt = DRV_B;
      DRV_B: state_nxt = WAIT;
      WAIT:  if (mul_done || tmo_hit) state_nxt = RESP;
      RESP: begin
        rsp_valid[win_q] = 1'b1;
        rsp_product      = err_q ? '0 : {hi_q, lo_q};
        rsp_err          = err_q;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The bus enable is registered off the next state, so the pin never sees decode glitches.
  assign mul_databus = bus_oe ? bus_dat : {BYTE_W{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= IDX_W'(N_REQ - 1);
      win_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      timer   <= '0;
      err_q   <= 1'b0;
      bus_oe  <= 1'b0;
      bus_dat <= '0;
    end else begin
      state   <= state_nxt;
      bus_oe  <= (state_nxt == DRV_A) || (state_nxt == DRV_B);
      bus_dat <= (state_nxt == DRV_A) ? a_q : b_q;
      case (state)
        IDLE: if (arb_vld) begin
          rr_ptr <= arb_idx;
          win_q  <= arb_idx;
          a_q    <= op_a[BYTE_W*arb_idx +: BYTE_W];
          b_q    <= op_b[BYTE_W*arb_idx +: BYTE_W];
          lo_q   <= '0;
          hi_q   <= '0;
          timer  <= '0;
          err_q  <= 1'b0;
        end
        WAIT: begin
          if (mul_lsb_out) lo_q <= mul_databus;
          if (mul_msb_out) hi_q <= mul_databus;
          // When mul_done arrives on the final timer cycle, the operation completes normally.
          if (!mul_done && tmo_hit) err_q <= 1'b1;
          timer <= timer + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_sequencer.sv
// Bench for mult_share_sequencer: a bus-level multiplier model, a grant/response scoreboard, and directed steps.
// Undriven bus is pulled up, so high-Z reads back as 8'hFF.
module tb_mult_share_sequencer;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;

  typedef struct {
    int          idx;
    logic [15:0] prod;
    logic        err;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N_REQ-1:0]     req = '0;
  logic [8*N_REQ-1:0]   op_a = '0;
  logic [8*N_REQ-1:0]   op_b = '0;
  logic [N_REQ-1:0]     gnt, rsp_valid;
  logic [15:0]          rsp_product;
  logic                 rsp_err, busy, mul_start;
  wire  [7:0]           mul_databus;
  logic                 mul_lsb_out = 1'b0;
  logic                 mul_msb_out = 1'b0;
  logic                 mul_done = 1'b0;
  logic                 mdl_oe = 1'b0;
  logic [7:0]           mdl_dat = '0;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int start_cyc = 0, done_cyc = 0, rsp_cyc = 0, gnt_cyc = 0;

  int          gq[$];
  exp_t        sq[$];
  int          mdl_ph = 0;
  int          dcnt = 0;
  int          mdl_delay = 2;
  bit          mdl_no_done = 1'b0;
  bit          mdl_combo = 1'b0;
  logic [7:0]  cap_a = '0, cap_b = '0;
  logic [15:0] mprod = '0;

  assign mul_databus = mdl_oe ? mdl_dat : 8'hzz;
  pullup pu (mul_databus);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_share_sequencer #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .op_a        (op_a),
    .op_b        (op_b),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .mul_start   (mul_start),
    .mul_databus (mul_databus),
    .mul_lsb_out (mul_lsb_out),
    .mul_msb_out (mul_msb_out),
    .mul_done    (mul_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Multiplier model: captures A and B from the bus, then returns the two product bytes and pulses done.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mdl_ph = 0; mdl_oe = 1'b0;
        mul_lsb_out = 1'b0; mul_msb_out = 1'b0; mul_done = 1'b0;
      end else begin
        case (mdl_ph)
          0: begin
            chk("bus_idle_z", mul_databus, 8'hFF);
            if (mul_start) begin start_cyc = cyc; mdl_ph = 1; end
          end
          1: begin cap_a = mul_databus; mdl_ph = 2; end
          2: begin cap_b = mul_databus; mprod = cap_a * cap_b; dcnt = 0; mdl_ph = 3; end
          3: begin
            chk("bus_wait_z", mul_databus, 8'hFF);
            if (dcnt == mdl_delay) begin
              mdl_oe = 1'b1;
              if (mdl_combo) begin mul_msb_out = 1'b1; mdl_dat = mprod[15:8]; end
              else begin mul_lsb_out = 1'b1; mdl_dat = mprod[7:0]; end
              mdl_ph = 4;
            end else dcnt++;
          end
          4: begin
            chk("bus_byte1", mul_databus, mdl_dat);
            if (mdl_combo) begin
              mul_msb_out = 1'b0; mul_lsb_out = 1'b1; mdl_dat = mprod[7:0];
              mul_done = !mdl_no_done; done_cyc = cyc;
            end else begin
              mul_lsb_out = 1'b0; mul_msb_out = 1'b1; mdl_dat = mprod[15:8];
            end
            mdl_ph = 5;
          end
          5: begin
            chk("bus_byte2", mul_databus, mdl_dat);
            mul_lsb_out = 1'b0; mul_msb_out = 1'b0; mdl_oe = 1'b0;
            if (mdl_combo) begin mul_done = 1'b0; mdl_ph = 0; end
            else if (mdl_no_done) mdl_ph = 6;
            else begin mul_done = 1'b1; done_cyc = cyc; mdl_ph = 7; end
          end
          6: begin
            chk("bus_tmo_z", mul_databus, 8'hFF);
            if (rsp_valid != '0) mdl_ph = 0;
          end
          7: begin
            chk("bus_resp_z", mul_databus, 8'hFF);
            mul_done = 1'b0; mdl_ph = 0;
          end
          default: mdl_ph = 0;
        endcase
      end
    end
  end

  // Scoreboard: expected grants and responses are popped in order as the DUT produces them.
  initial begin
    int   ei;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (gnt != '0) begin
          gnt_cyc = cyc;
          if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'h0);
          else begin
            ei = gq.pop_front();
            chk("gnt_onehot", 32'(gnt), 32'(1 << ei));
            chk("gnt_busy", 32'(busy), 32'h1);
          end
        end
        if (rsp_valid != '0) begin
          rsp_cyc = cyc;
          if (sq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
          else begin
            e = sq.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
            chk("rsp_product", 32'(rsp_product), 32'(e.prod));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_busy", 32'(busy), 32'h1);
          end
        end
      end
    end
  end

  task automatic wait_gnt(input int i);
    bit seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (gnt[i]) seen = 1'b1;
    end
    chk("gnt_wait", 32'(seen), 32'h1);
  endtask

  task automatic wait_drain();
    int c = 0;
    while (sq.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("rsp_drain", 32'(sq.size()), 32'h0);
  endtask

  task automatic push_exp(input int i, input logic [7:0] a, input logic [7:0] b, input bit err);
    exp_t        e;
    logic [15:0] p;
    p      = a * b;
    e.idx  = i;
    e.prod = err ? 16'h0000 : p;
    e.err  = err;
    sq.push_back(e);
  endtask

  task automatic do_req(input int i, input logic [7:0] a, input logic [7:0] b,
                        input bit err, input bit rsp);
    gq.push_back(i);
    if (rsp) push_exp(i, a, b, err);
    @(posedge clk); #1;
    op_a[8*i +: 8] = a;
    op_b[8*i +: 8] = b;
    req[i] = 1'b1;
    wait_gnt(i);
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    // Outputs while held in reset
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mul_start", 32'(mul_start), 32'h0);
    chk("rst_product", 32'(rsp_product), 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    chk("rst_bus_z", 32'(mul_databus), 32'hFF);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request from client 0: 7 * 9
    do_req(0, 8'd7, 8'd9, 1'b0, 1'b1);
    wait_drain();
    chk("single_cap_a", 32'(cap_a), 32'h07);
    chk("single_cap_b", 32'(cap_b), 32'h09);
    chk("start_latency", 32'(start_cyc - gnt_cyc), 32'd1);
    chk("rsp_latency", 32'(rsp_cyc - done_cyc), 32'd1);

    // Max operands from client 2
    do_req(2, 8'hFF, 8'hFF, 1'b0, 1'b1);
    wait_drain();
    chk("max_cap_a", 32'(cap_a), 32'hFF);
    chk("max_cap_b", 32'(cap_b), 32'hFF);

    // High byte first, then low byte together with done
    mdl_combo = 1'b1;
    do_req(1, 8'h12, 8'h34, 1'b0, 1'b1);
    wait_drain();
    chk("combo_rsp_latency", 32'(rsp_cyc - done_cyc), 32'd1);
    mdl_combo = 1'b0;

    // Reset while the DUT sits in WAIT: no response and the bus floats
    mdl_delay = 6;
    do_req(3, 8'h21, 8'h03, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_bus_z", 32'(mul_databus), 32'hFF);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("midrst_rsp_valid2", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_delay = 2;
    repeat (10) @(negedge clk);
    chk("midrst_no_pending_gnt", 32'(gq.size()), 32'h0);

    // Fairness: all four requests held high, so grants go 0,1,2,3,0
    for (int i = 0; i < N_REQ; i++) begin
      op_a[8*i +: 8] = 8'(i + 3);
      op_b[8*i +: 8] = 8'(i * 17 + 1);
    end
    for (int k = 0; k < 5; k++) begin
      gq.push_back(order[k]);
      push_exp(order[k], 8'(order[k] + 3), 8'(order[k] * 17 + 1), 1'b0);
    end
    @(posedge clk); #1;
    req = '1;
    for (int k = 0; k < 5; k++) wait_gnt(order[k]);
    @(posedge clk); #1;
    req = '0;
    wait_drain();

    // Timeout: mul_done never comes
    mdl_no_done = 1'b1;
    do_req(1, 8'h05, 8'h06, 1'b1, 1'b1);
    wait_drain();
    chk("tmo_latency", 32'(rsp_cyc - start_cyc), 32'(3 + TIMEOUT));
    mdl_no_done = 1'b0;

    // Normal operation afterwards; a short req from client 3 while busy is never granted
    do_req(2, 8'h10, 8'h10, 1'b0, 1'b1);
    req[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1 req[3] = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);
    chk("post_cap_a", 32'(cap_a), 32'h10);
    chk("post_idle_busy", 32'(busy), 32'h0);
    chk("post_no_pending_gnt", 32'(gq.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
